// File: rtl/cr_huf_compPKG.sv
// Shared types for the Huffman compressor pipeline: block-end markers,
// sequence-id width and the symbol-count packer state.
package cr_huf_compPKG;

    localparam int CREOLE_HC_SEQID_WIDTH = 8;
    localparam int SC_NUM_LANES          = 4;

    typedef enum logic [1:0] {
        MIDDLE    = 2'd0,
        PASS1_EOB = 2'd1,
        PASS2_EOB = 2'd2,
        FINAL_EOB = 2'd3
    } e_pipe_eob;

    typedef enum logic {
        SC_RUN   = 1'b0,
        SC_FLUSH = 1'b1
    } e_sc_pack_state;

endpackage

// File: rtl/cr_huf_comp_sc_run.sv
// Run accumulator: merges consecutive identical symbols into one (sym, cnt)
// pair and signals when the held run has to be handed to the lane buffer.
module cr_huf_comp_sc_run #(
    parameter int DAT_WIDTH        = 10,
    parameter int CNT_WIDTH        = 3,
    parameter int MAX_NUM_SYM_USED = 576
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sym_acc,
    input  logic [DAT_WIDTH-1:0] sym,
    input  logic                 clear,
    output logic                 r_val,
    output logic [DAT_WIDTH-1:0] r_sym,
    output logic [CNT_WIDTH-1:0] r_cnt,
    output logic                 push
);

    localparam logic [DAT_WIDTH:0] SYM_LIMIT = (DAT_WIDTH+1)'(MAX_NUM_SYM_USED);

    logic drop;
    logic keep;

    assign drop = {1'b0, sym} >= SYM_LIMIT;
    assign keep = sym_acc && !drop;
    // A saturated count forces a new run even when the symbol repeats.
    assign push = keep && r_val && ((sym != r_sym) || (r_cnt == '1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val <= 1'b0;
            r_sym <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_val <= 1'b0;
            r_sym <= '0;
            r_cnt <= '0;
        end else if (keep) begin
            if (!r_val || push) begin
                r_val <= 1'b1;
                r_sym <= sym;
                r_cnt <= CNT_WIDTH'(1);
            end else begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/cr_huf_comp_sc_packer.sv
// Symbol-count packer: collects runs into four lanes per output beat and
// flushes a short, eob-tagged final beat at the end of every block.
module cr_huf_comp_sc_packer
    import cr_huf_compPKG::*;
#(
    parameter int DAT_WIDTH        = 10,
    parameter int CNT_WIDTH        = 3,
    parameter int CNTRL_WIDTH      = 1,
    parameter int MAX_NUM_SYM_USED = 576
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_vld,
    output logic                             in_rdy,
    input  logic [DAT_WIDTH-1:0]             in_sym,
    input  e_pipe_eob                        in_eob,
    input  logic [CREOLE_HC_SEQID_WIDTH-1:0] in_seq_id,
    input  logic [CNTRL_WIDTH-1:0]           in_meta,
    output logic [3:0]                       sc_is_vld,
    output logic [DAT_WIDTH-1:0]             sc_is_sym0,
    output logic [DAT_WIDTH-1:0]             sc_is_sym1,
    output logic [DAT_WIDTH-1:0]             sc_is_sym2,
    output logic [DAT_WIDTH-1:0]             sc_is_sym3,
    output logic [CNT_WIDTH-1:0]             sc_is_cnt0,
    output logic [CNT_WIDTH-1:0]             sc_is_cnt1,
    output logic [CNT_WIDTH-1:0]             sc_is_cnt2,
    output logic [CNT_WIDTH-1:0]             sc_is_cnt3,
    output logic [CNTRL_WIDTH-1:0]           sc_is_meta,
    output logic [CREOLE_HC_SEQID_WIDTH-1:0] sc_is_seq_id,
    output e_pipe_eob                        sc_is_eob,
    input  logic                             is_sc_rd
);

    localparam logic [2:0] LANES_FULL = 3'(SC_NUM_LANES);

    e_sc_pack_state                   state;
    e_pipe_eob                        eob_lat;
    logic                             block_first;
    logic [CREOLE_HC_SEQID_WIDTH-1:0] seq_lat;
    logic [CNTRL_WIDTH-1:0]           meta_lat;
    logic [2:0]                       lc;
    logic [DAT_WIDTH-1:0]             lane_sym [SC_NUM_LANES];
    logic [CNT_WIDTH-1:0]             lane_cnt [SC_NUM_LANES];
    logic [DAT_WIDTH-1:0]             o_sym    [SC_NUM_LANES];
    logic [CNT_WIDTH-1:0]             o_cnt    [SC_NUM_LANES];
    logic [DAT_WIDTH-1:0]             fin_sym  [SC_NUM_LANES];
    logic [CNT_WIDTH-1:0]             fin_cnt  [SC_NUM_LANES];
    logic [3:0]                       fin_vld;

    logic                 r_val;
    logic [DAT_WIDTH-1:0] r_sym;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 push;
    logic [1:0]           push_idx;
    logic                 o_valid;
    logic                 o_load_ok;
    logic                 lanes_full;
    logic                 accept;
    logic                 emit_full;
    logic                 emit_final;

    assign lanes_full = (lc == LANES_FULL);
    assign o_valid    = |sc_is_vld;
    assign o_load_ok  = !o_valid || is_sc_rd;
    assign in_rdy     = (state == SC_RUN) && (!lanes_full || o_load_ok);
    assign accept     = in_vld && in_rdy;
    assign emit_full  = lanes_full && o_load_ok;
    assign emit_final = (state == SC_FLUSH) && !lanes_full && o_load_ok;
    // A push landing in the same cycle as a full-beat move starts the emptied buffer.
    assign push_idx   = emit_full ? 2'd0 : lc[1:0];

    cr_huf_comp_sc_run #(
        .DAT_WIDTH        (DAT_WIDTH),
        .CNT_WIDTH        (CNT_WIDTH),
        .MAX_NUM_SYM_USED (MAX_NUM_SYM_USED)
    ) u_run (
        .clk     (clk),
        .rst     (rst),
        .sym_acc (accept),
        .sym     (in_sym),
        .clear   (emit_final),
        .r_val   (r_val),
        .r_sym   (r_sym),
        .r_cnt   (r_cnt),
        .push    (push)
    );

    // Final beat: filled lanes, then the open run, with an empty lane 0 when nothing else is valid.
    always_comb begin
        fin_vld = '0;
        for (int i = 0; i < SC_NUM_LANES; i++) begin
            fin_sym[i] = '0;
            fin_cnt[i] = '0;
            if (3'(i) < lc) begin
                fin_sym[i] = lane_sym[i];
                fin_cnt[i] = lane_cnt[i];
                fin_vld[i] = 1'b1;
            end else if ((3'(i) == lc) && r_val) begin
                fin_sym[i] = r_sym;
                fin_cnt[i] = r_cnt;
                fin_vld[i] = 1'b1;
            end
        end
        if (fin_vld == '0) begin
            fin_vld = 4'b0001;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SC_RUN;
            eob_lat      <= MIDDLE;
            block_first  <= 1'b1;
            seq_lat      <= '0;
            meta_lat     <= '0;
            lc           <= '0;
            sc_is_vld    <= '0;
            sc_is_eob    <= MIDDLE;
            sc_is_seq_id <= '0;
            sc_is_meta   <= '0;
            for (int i = 0; i < SC_NUM_LANES; i++) begin
                lane_sym[i] <= '0;
                lane_cnt[i] <= '0;
                o_sym[i]    <= '0;
                o_cnt[i]    <= '0;
            end
        end else begin
            case (state)
                SC_RUN: begin
                    if (accept && (in_eob != MIDDLE)) begin
                        state   <= SC_FLUSH;
                        eob_lat <= in_eob;
                    end
                end
                SC_FLUSH: begin
                    if (emit_final) begin
                        state <= SC_RUN;
                    end
                end
                default: state <= SC_RUN;
            endcase

            if (emit_final) begin
                block_first <= 1'b1;
            end else if (accept) begin
                block_first <= 1'b0;
            end
            if (accept && block_first) begin
                seq_lat  <= in_seq_id;
                meta_lat <= in_meta;
            end

            for (int i = 0; i < SC_NUM_LANES; i++) begin
                if (push && (push_idx == 2'(i))) begin
                    lane_sym[i] <= r_sym;
                    lane_cnt[i] <= r_cnt;
                end
            end
            if (emit_full || emit_final) begin
                lc <= push ? 3'd1 : 3'd0;
            end else if (push) begin
                lc <= lc + 3'd1;
            end

            if (emit_full) begin
                o_sym        <= lane_sym;
                o_cnt        <= lane_cnt;
                sc_is_vld    <= 4'b1111;
                sc_is_eob    <= MIDDLE;
                sc_is_seq_id <= seq_lat;
                sc_is_meta   <= meta_lat;
            end else if (emit_final) begin
                o_sym        <= fin_sym;
                o_cnt        <= fin_cnt;
                sc_is_vld    <= fin_vld;
                sc_is_eob    <= eob_lat;
                sc_is_seq_id <= seq_lat;
                sc_is_meta   <= meta_lat;
            end else if (o_valid && is_sc_rd) begin
                sc_is_vld <= '0;
            end
        end
    end

    assign sc_is_sym0 = o_sym[0];
    assign sc_is_sym1 = o_sym[1];
    assign sc_is_sym2 = o_sym[2];
    assign sc_is_sym3 = o_sym[3];
    assign sc_is_cnt0 = o_cnt[0];
    assign sc_is_cnt1 = o_cnt[1];
    assign sc_is_cnt2 = o_cnt[2];
    assign sc_is_cnt3 = o_cnt[3];

endmodule

// File: tb/tb_cr_huf_comp_sc_packer.sv
// Directed bench for the symbol-count packer: hand-computed beats are compared
// against everything the monitor sees consumed downstream.
module tb_cr_huf_comp_sc_packer;
    import cr_huf_compPKG::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [9:0]  in_sym;
    e_pipe_eob   in_eob;
    logic [7:0]  in_seq_id;
    logic [0:0]  in_meta;
    logic [3:0]  sc_is_vld;
    logic [9:0]  sc_is_sym0, sc_is_sym1, sc_is_sym2, sc_is_sym3;
    logic [2:0]  sc_is_cnt0, sc_is_cnt1, sc_is_cnt2, sc_is_cnt3;
    logic [0:0]  sc_is_meta;
    logic [7:0]  sc_is_seq_id;
    e_pipe_eob   sc_is_eob;
    logic        is_sc_rd;

    typedef struct {
        logic [3:0]  vld;
        logic [39:0] syms;
        logic [11:0] cnts;
        logic [1:0]  eob;
        logic [7:0]  seq;
        logic        meta;
    } beat_t;

    beat_t beat_q[$];
    beat_t exp_q[$];
    beat_t mon_beat;
    int    num_checks = 0;
    int    num_fails  = 0;

    cr_huf_comp_sc_packer dut (
        .clk          (clk),
        .rst          (rst),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_sym       (in_sym),
        .in_eob       (in_eob),
        .in_seq_id    (in_seq_id),
        .in_meta      (in_meta),
        .sc_is_vld    (sc_is_vld),
        .sc_is_sym0   (sc_is_sym0),
        .sc_is_sym1   (sc_is_sym1),
        .sc_is_sym2   (sc_is_sym2),
        .sc_is_sym3   (sc_is_sym3),
        .sc_is_cnt0   (sc_is_cnt0),
        .sc_is_cnt1   (sc_is_cnt1),
        .sc_is_cnt2   (sc_is_cnt2),
        .sc_is_cnt3   (sc_is_cnt3),
        .sc_is_meta   (sc_is_meta),
        .sc_is_seq_id (sc_is_seq_id),
        .sc_is_eob    (sc_is_eob),
        .is_sc_rd     (is_sc_rd)
    );

    always #5 clk = ~clk;

    // Record every beat that the downstream side consumes on the next rising edge.
    always @(negedge clk) begin
        #2;
        if (!rst && (|sc_is_vld) && is_sc_rd) begin
            mon_beat.vld  = sc_is_vld;
            mon_beat.syms = {sc_is_sym3, sc_is_sym2, sc_is_sym1, sc_is_sym0};
            mon_beat.cnts = {sc_is_cnt3, sc_is_cnt2, sc_is_cnt1, sc_is_cnt0};
            mon_beat.eob  = sc_is_eob;
            mon_beat.seq  = sc_is_seq_id;
            mon_beat.meta = sc_is_meta[0];
            beat_q.push_back(mon_beat);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic expectBeat(input logic [3:0] vld, input logic [39:0] syms, input logic [11:0] cnts,
                              input logic [1:0] eob, input logic [7:0] seq, input logic meta);
        beat_t b;
        b.vld = vld; b.syms = syms; b.cnts = cnts; b.eob = eob; b.seq = seq; b.meta = meta;
        exp_q.push_back(b);
    endtask

    // Present one symbol and hold it until the packer accepts it.
    task automatic applyStimulus(input logic [9:0] sym, input e_pipe_eob eob, input logic [7:0] seq, input logic meta);
        int w = 0;
        in_vld    = 1'b1;
        in_sym    = sym;
        in_eob    = eob;
        in_seq_id = seq;
        in_meta   = meta;
        #1;
        while (!in_rdy && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_rdy) checkOutput("accept_timeout", {63'd0, in_rdy}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_vld = 1'b0;
        in_eob = MIDDLE;
    endtask

    task automatic checkBeats(input string tag);
        beat_t b, e;
        int    w = 0;
        while (beat_q.size() < exp_q.size() && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
        checkOutput({tag, "_count"}, 64'(beat_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && beat_q.size() > 0) begin
            e = exp_q.pop_front();
            b = beat_q.pop_front();
            checkOutput({tag, "_vld"},  64'(b.vld),  64'(e.vld));
            checkOutput({tag, "_syms"}, 64'(b.syms), 64'(e.syms));
            checkOutput({tag, "_cnts"}, 64'(b.cnts), 64'(e.cnts));
            checkOutput({tag, "_eob"},  64'(b.eob),  64'(e.eob));
            checkOutput({tag, "_seq"},  64'(b.seq),  64'(e.seq));
            checkOutput({tag, "_meta"}, 64'(b.meta), 64'(e.meta));
        end
        beat_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_sym = '0; in_eob = MIDDLE;
        in_seq_id = '0; in_meta = '0; is_sc_rd = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_vld",  64'(sc_is_vld),    64'd0);
        checkOutput("rst_eob",  64'(sc_is_eob),    64'(MIDDLE));
        checkOutput("rst_sym0", 64'(sc_is_sym0),   64'd0);
        checkOutput("rst_cnt0", 64'(sc_is_cnt0),   64'd0);
        checkOutput("rst_seq",  64'(sc_is_seq_id), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_rdy", {63'd0, in_rdy}, 64'd1);

        // Run merge with latency check on the final beat.
        applyStimulus(10'd5, MIDDLE, 8'h11, 1'b1);
        applyStimulus(10'd5, MIDDLE, 8'hEE, 1'b0);
        applyStimulus(10'd5, MIDDLE, 8'hEE, 1'b0);
        applyStimulus(10'd9, FINAL_EOB, 8'hEE, 1'b0);
        #1;
        checkOutput("lat_n1_vld", 64'(sc_is_vld), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("lat_n2_vld", 64'(sc_is_vld), 64'b0011);
        expectBeat(4'b0011, {10'd0, 10'd0, 10'd9, 10'd5}, {3'd0, 3'd0, 3'd1, 3'd3}, 2'd3, 8'h11, 1'b1);
        checkBeats("merge");

        // Count saturation splits a long run across lanes.
        for (int i = 0; i < 10; i++) applyStimulus(10'd7, MIDDLE, (i == 0) ? 8'h22 : 8'hDD, 1'b0);
        applyStimulus(10'd8, PASS1_EOB, 8'hDD, 1'b1);
        expectBeat(4'b0111, {10'd0, 10'd8, 10'd7, 10'd7}, {3'd0, 3'd1, 3'd3, 3'd7}, 2'd1, 8'h22, 1'b0);
        checkBeats("sat");

        // Six distinct symbols: one full beat then a two-lane final beat.
        for (int i = 1; i <= 6; i++)
            applyStimulus(10'(i), (i == 6) ? FINAL_EOB : MIDDLE, (i == 1) ? 8'h33 : 8'hCC, (i == 1));
        expectBeat(4'b1111, {10'd4, 10'd3, 10'd2, 10'd1}, {3'd1, 3'd1, 3'd1, 3'd1}, 2'd0, 8'h33, 1'b1);
        expectBeat(4'b0011, {10'd0, 10'd0, 10'd6, 10'd5}, {3'd0, 3'd0, 3'd1, 3'd1}, 2'd3, 8'h33, 1'b1);
        checkBeats("full");

        // Backpressure: the beat must hold and the input must stall with full lanes.
        is_sc_rd = 1'b0;
        for (int i = 1; i <= 9; i++) applyStimulus(10'(i), MIDDLE, (i == 1) ? 8'h44 : 8'hBB, 1'b0);
        in_vld = 1'b1; in_sym = 10'd10; in_eob = FINAL_EOB; in_seq_id = 8'hBB; in_meta = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            checkOutput("bp_rdy",  {63'd0, in_rdy},   64'd0);
            checkOutput("bp_vld",  64'(sc_is_vld),    64'b1111);
            checkOutput("bp_sym0", 64'(sc_is_sym0),   64'd1);
            checkOutput("bp_sym3", 64'(sc_is_sym3),   64'd4);
            @(negedge clk);
        end
        is_sc_rd = 1'b1;
        #1;
        checkOutput("bp_rdy_release", {63'd0, in_rdy}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_vld = 1'b0; in_eob = MIDDLE;
        expectBeat(4'b1111, {10'd4, 10'd3, 10'd2, 10'd1}, {3'd1, 3'd1, 3'd1, 3'd1}, 2'd0, 8'h44, 1'b0);
        expectBeat(4'b1111, {10'd8, 10'd7, 10'd6, 10'd5}, {3'd1, 3'd1, 3'd1, 3'd1}, 2'd0, 8'h44, 1'b0);
        expectBeat(4'b0011, {10'd0, 10'd0, 10'd10, 10'd9}, {3'd0, 3'd0, 3'd1, 3'd1}, 2'd3, 8'h44, 1'b0);
        checkBeats("bp");

        // Every symbol dropped: eob still delivered on an empty lane 0.
        applyStimulus(10'd600, MIDDLE, 8'h55, 1'b1);
        applyStimulus(10'd700, PASS2_EOB, 8'hAA, 1'b0);
        expectBeat(4'b0001, 40'd0, 12'd0, 2'd2, 8'h55, 1'b1);
        checkBeats("drop_all");

        // Drop threshold boundary: 576 vanishes without breaking the 575 run.
        applyStimulus(10'd576, MIDDLE, 8'h5A, 1'b0);
        applyStimulus(10'd575, MIDDLE, 8'hA5, 1'b1);
        applyStimulus(10'd575, PASS1_EOB, 8'hA5, 1'b1);
        expectBeat(4'b0001, {10'd0, 10'd0, 10'd0, 10'd575}, {3'd0, 3'd0, 3'd0, 3'd2}, 2'd1, 8'h5A, 1'b0);
        checkBeats("drop_edge");

        // Reset mid-block with a full beat pending, then a clean block.
        is_sc_rd = 1'b0;
        for (int i = 11; i <= 15; i++) applyStimulus(10'(i), MIDDLE, 8'h77, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("rstmid_pre_vld", 64'(sc_is_vld), 64'b1111);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_vld",  64'(sc_is_vld),  64'd0);
        checkOutput("rstmid_sym0", 64'(sc_is_sym0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        is_sc_rd = 1'b1;
        applyStimulus(10'd3, MIDDLE, 8'h66, 1'b1);
        applyStimulus(10'd3, FINAL_EOB, 8'h99, 1'b0);
        expectBeat(4'b0001, {10'd0, 10'd0, 10'd0, 10'd3}, {3'd0, 3'd0, 3'd0, 3'd2}, 2'd3, 8'h66, 1'b1);
        checkBeats("rstmid");

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
